id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the MIPS32 core; sits directly upstream of the ALU.
- Captures decoded operands and control from decode, then drives the ALU inputs a, b and ControlALU.
- Supplies EX/MEM with destination and memory control.
- Resolves RAW data hazards by forwarding EX/MEM and MEM/WB results onto the ALU operands; supports stall (hold) and flush (bubble insertion).

Parameters:
- DATA_W, 32, operand/result width
- REG_W, 5, register-number width
- CTRL_W, 3, ALU control width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold current contents
- flush  in  1  replace contents with bubble
- id_valid  in  1  decode slot holds a real instruction
- id_rs_data  in  DATA_W  register-file read port 1
- id_rt_data  in  DATA_W  register-file read port 2
- id_imm  in  DATA_W  sign-extended immediate
- id_rs  in  REG_W  source register number 1
- id_rt  in  REG_W  source register number 2
- id_rd  in  REG_W  destination register number (already muxed rt/rd)
- id_alu_ctrl  in  CTRL_W  ALU operation
- id_alu_src  in  1  1 selects immediate for ALU b
- id_reg_write  in  1  control bit
- id_mem_read  in  1  control bit
- id_mem_write  in  1  control bit
- id_mem_to_reg  in  1  control bit
- mem_rd  in  REG_W  EX/MEM destination
- mem_reg_write  in  1  EX/MEM write enable
- mem_result  in  DATA_W  EX/MEM ALU result
- wb_rd  in  REG_W  MEM/WB destination
- wb_reg_write  in  1  MEM/WB write enable
- wb_result  in  DATA_W  MEM/WB writeback value
- ex_valid  out  1  EX slot valid
- alu_a  out  DATA_W  to ALU a
- alu_b  out  DATA_W  to ALU b
- control_alu  out  CTRL_W  to ALU ControlALU
- ex_store_data  out  DATA_W  forwarded rt value for stores
- ex_rd  out  REG_W  destination to EX/MEM
- ex_reg_write  out  1  registered control
- ex_mem_read  out  1  registered control
- ex_mem_write  out  1  registered control
- ex_mem_to_reg  out  1  registered control
- fwd_a  out  2  forward select for a (debug/verification)
- fwd_b  out  2  forward select for rt path (debug/verification)

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0.
  - ex_valid=0, control_alu=3'b000, ex_rd=0, all ex_* control bits 0, stored data/imm/register numbers 0.
  - Effect persists until the first edge after release.
- Per rising edge, priority flush > stall > load:
  - flush=1: bubble. valid=0 and all control bits 0; control_alu=000; data registers are don't-care but set to 0.
  - stall=1, flush=0: every register holds.
  - Otherwise: load all id_* inputs. If id_valid=0, load a bubble instead.
- Latency: 1 cycle from ID inputs to EX outputs.
- Forwarding (combinational from registered rs/rt and the live mem_*/wb_* inputs); applies separately to rs→a and rt→b/store:
  - 2'b10 (MEM): mem_reg_write=1, mem_rd!=0, mem_rd==src.
  - 2'b01 (WB): else if wb_reg_write=1, wb_rd!=0, wb_rd==src.
  - 2'b00: register-file value.
  - MEM wins over WB when both match.
  - Register 0 is never forwarded.
  - Forwarding is suppressed (select 00) when ex_valid=0.
- alu_a = forwarded rs value.
- alu_b = alu_src ? imm : forwarded rt value.
- ex_store_data = forwarded rt value, always, regardless of alu_src.
- During stall the forward selects keep re-evaluating against live mem/wb inputs.
- A flush asserted with stall on the same edge produces a bubble.

Optional Feature:
- Macro: ID_EX_FWD_EN
- Defined: forwarding exactly as above.
- Undefined:
  - fwd_a/fwd_b tied to 00.
  - alu_a = registered rs data; alu_b/ex_store_data use registered rt data.
  - Hazards are left to the stall logic; the forwarding sub-module is not instantiated.

Decomposition:
- Package mips_pkg holds:
  - ALU codes: ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_SLT=3'b111.
  - Forward selects: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - DATA_W/REG_W constants.
- One sub-module: fwd_unit (purely combinational select generation for one source operand, instantiated twice).

Test Plan:
- Reset mid-run: rst_n low with ex_valid=1 → outputs immediately 0, control_alu=000, ex_valid=0.
- Plain load: id_rs_data=1, id_rt_data=2, id_alu_ctrl=010, alu_src=0, no hazards → next cycle alu_a=1, alu_b=2, control_alu=010, fwd_a=fwd_b=00.
- Double hazard:
  - Setup: rs=rt=5, mem_rd=5 (result 0x10), wb_rd=5 (result 0x20), both writes set.
  - Expect: alu_a=alu_b=0x10, fwd=10.
  - Then drop mem_reg_write → expect 0x20, fwd=01.
- Register zero: rs=0, mem_rd=0, mem_reg_write=1, mem_result=0xFFFF → alu_a=registered rs data, fwd_a=00.
- Immediate with store:
  - Setup: alu_src=1, imm=0xFFFFFFFC, mem_write=1, rt forwarded from WB = 0x55.
  - Expect: alu_b=0xFFFFFFFC, ex_store_data=0x55.
- Stall/flush:
  - stall 3 cycles → all outputs held.
  - stall+flush same edge → bubble (ex_valid=0, ex_reg_write=0, control_alu=000).
  - id_valid=0 → bubble.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS32 datapath: widths, ALU operation codes and
// forwarding-select encodings.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CTRL_W = 3;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Forward-select generation for one ALU source operand. EX/MEM beats MEM/WB;
// register 0 and empty EX slots never forward.
module fwd_unit
  import mips_pkg::*;
#(
  parameter int REG_W = mips_pkg::REG_W
) (
  input  logic             i_valid,
  input  logic [REG_W-1:0] i_src,
  input  logic [REG_W-1:0] i_mem_rd,
  input  logic             i_mem_reg_write,
  input  logic [REG_W-1:0] i_wb_rd,
  input  logic             i_wb_reg_write,
  output fwd_sel_e         o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    // a non-zero src that matches implies the producer rd is non-zero too
    if (i_valid && (i_src != '0)) begin
      if (i_mem_reg_write && (i_mem_rd == i_src)) begin
        o_sel = FWD_MEM;
      end else if (i_wb_reg_write && (i_wb_rd == i_src)) begin
        o_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding into the ALU inputs.
// Forwarding is built only when ID_EX_FWD_EN is defined; otherwise the RF values pass straight through.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_W  = mips_pkg::REG_W,
  parameter int CTRL_W = mips_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [CTRL_W-1:0] id_alu_ctrl,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic              mem_reg_write,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic              wb_reg_write,
  input  logic [DATA_W-1:0] wb_result,
  output logic              ex_valid,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] control_alu,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_W-1:0]  ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  logic              r_valid;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [REG_W-1:0]  r_rs;
  logic [REG_W-1:0]  r_rt;
  logic [REG_W-1:0]  r_rd;
  logic [CTRL_W-1:0] r_alu_ctrl;
  logic              r_alu_src;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_mem_to_reg;

  fwd_sel_e          w_fwd_a;
  fwd_sel_e          w_fwd_b;
  logic [DATA_W-1:0] w_rs_fwd;
  logic [DATA_W-1:0] w_rt_fwd;
  logic              w_load;

  // flush, reset and an empty decode slot all leave the same all-zero bubble
  assign w_load = id_valid && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_alu_ctrl   <= '0;
      r_alu_src    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (flush || !stall) begin
      r_valid      <= w_load;
      r_rs_data    <= w_load ? id_rs_data : '0;
      r_rt_data    <= w_load ? id_rt_data : '0;
      r_imm        <= w_load ? id_imm : '0;
      r_rs         <= w_load ? id_rs : '0;
      r_rt         <= w_load ? id_rt : '0;
      r_rd         <= w_load ? id_rd : '0;
      r_alu_ctrl   <= w_load ? id_alu_ctrl : '0;
      r_alu_src    <= w_load && id_alu_src;
      r_reg_write  <= w_load && id_reg_write;
      r_mem_read   <= w_load && id_mem_read;
      r_mem_write  <= w_load && id_mem_write;
      r_mem_to_reg <= w_load && id_mem_to_reg;
    end
  end

`ifdef ID_EX_FWD_EN
  fwd_unit #(.REG_W(REG_W)) u_fwd_a (
    .i_valid         (r_valid),
    .i_src           (r_rs),
    .i_mem_rd        (mem_rd),
    .i_mem_reg_write (mem_reg_write),
    .i_wb_rd         (wb_rd),
    .i_wb_reg_write  (wb_reg_write),
    .o_sel           (w_fwd_a)
  );

  fwd_unit #(.REG_W(REG_W)) u_fwd_b (
    .i_valid         (r_valid),
    .i_src           (r_rt),
    .i_mem_rd        (mem_rd),
    .i_mem_reg_write (mem_reg_write),
    .i_wb_rd         (wb_rd),
    .i_wb_reg_write  (wb_reg_write),
    .o_sel           (w_fwd_b)
  );
`else
  logic w_unused_fwd;

  assign w_fwd_a      = FWD_RF;
  assign w_fwd_b      = FWD_RF;
  assign w_unused_fwd = ^{r_rs, r_rt, mem_rd, mem_reg_write, wb_rd, wb_reg_write};
`endif

  always_comb begin
    w_rs_fwd = r_rs_data;
    case (w_fwd_a)
      FWD_MEM: w_rs_fwd = mem_result;
      FWD_WB:  w_rs_fwd = wb_result;
      default: w_rs_fwd = r_rs_data;
    endcase
  end

  always_comb begin
    w_rt_fwd = r_rt_data;
    case (w_fwd_b)
      FWD_MEM: w_rt_fwd = mem_result;
      FWD_WB:  w_rt_fwd = wb_result;
      default: w_rt_fwd = r_rt_data;
    endcase
  end

  assign alu_a         = w_rs_fwd;
  assign alu_b         = r_alu_src ? r_imm : w_rt_fwd;
  assign ex_store_data = w_rt_fwd;
  assign fwd_a         = w_fwd_a;
  assign fwd_b         = w_fwd_b;

  assign ex_valid      = r_valid;
  assign control_alu   = r_alu_ctrl;
  assign ex_rd         = r_rd;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_mem_to_reg = r_mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push hand-computed EX
// outputs into a queue, a negedge monitor pops and compares.
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [2:0]  id_alu_ctrl;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_result;
  logic        ex_valid;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [2:0]  control_alu;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [1:0]  fwd_a, fwd_b;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_ctrl(id_alu_ctrl),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .control_alu(control_alu),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  typedef struct {
    string       name;
    logic        v;
    logic [31:0] a, b, st;
    logic [2:0]  c;
    logic [4:0]  rd;
    logic        rw, mr, mw, m2r;
    logic [1:0]  fa, fb;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic exp_t mk(input string n, input logic v, input logic [31:0] a, b, st,
                              input logic [2:0] c, input logic [4:0] rd,
                              input logic rw, mr, mw, m2r, input logic [1:0] fa, fb);
    exp_t e;
    e.name = n; e.v = v; e.a = a; e.b = b; e.st = st; e.c = c; e.rd = rd;
    e.rw = rw; e.mr = mr; e.mw = mw; e.m2r = m2r; e.fa = fa; e.fb = fb;
    return e;
  endfunction

  function automatic exp_t bubble(input string n);
    return mk(n, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 2'b00);
  endfunction

  // monitor: one comparison per negedge whenever an expectation is pending
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_total++;
        if (ex_valid === e.v && alu_a === e.a && alu_b === e.b && ex_store_data === e.st &&
            control_alu === e.c && ex_rd === e.rd && ex_reg_write === e.rw &&
            ex_mem_read === e.mr && ex_mem_write === e.mw && ex_mem_to_reg === e.m2r &&
            fwd_a === e.fa && fwd_b === e.fb)
          n_pass++;
        else
          $display("FAIL %s: got v=%b a=%h b=%h st=%h c=%b rd=%0d rw=%b mr=%b mw=%b m2r=%b fa=%b fb=%b | want v=%b a=%h b=%h st=%h c=%b rd=%0d rw=%b mr=%b mw=%b m2r=%b fa=%b fb=%b",
                   e.name, ex_valid, alu_a, alu_b, ex_store_data, control_alu, ex_rd,
                   ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, fwd_a, fwd_b,
                   e.v, e.a, e.b, e.st, e.c, e.rd, e.rw, e.mr, e.mw, e.m2r, e.fa, e.fb);
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] rsd, rtd, imm,
                       input logic [4:0] rs, rt, rd, input logic [2:0] c,
                       input logic src, rw, mr, mw, m2r);
    id_valid = v; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_rs = rs; id_rt = rt; id_rd = rd; id_alu_ctrl = c; id_alu_src = src;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
  endtask

  task automatic fw(input logic [4:0] mrd, input logic mrw, input logic [31:0] mres,
                    input logic [4:0] wrd, input logic wrw, input logic [31:0] wres);
    mem_rd = mrd; mem_reg_write = mrw; mem_result = mres;
    wb_rd = wrd; wb_reg_write = wrw; wb_result = wres;
  endtask

  // inputs change just after the monitor has sampled
  task automatic next();
    @(negedge clk);
    #1;
  endtask

  task automatic tick_push(input exp_t e);
    @(posedge clk);
    #1;
    q.push_back(e);
  endtask

  exp_t imm_exp;

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    fw(0, 0, 0, 0, 0, 0);
    #1 q.push_back(bubble("reset"));
    next();
    rst_n = 1'b1;

    drive(1, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd3, 3'b010, 0, 1, 0, 0, 0);
    tick_push(mk("plain_load", 1, 32'h1, 32'h2, 32'h2, 3'b010, 5'd3, 1, 0, 0, 0, 2'b00, 2'b00));

    next();
    drive(1, 32'hAAAA, 32'hBBBB, 32'h0, 5'd5, 5'd5, 5'd7, 3'b010, 0, 1, 0, 0, 0);
    fw(5'd5, 1, 32'h10, 5'd5, 1, 32'h20);
    tick_push(mk("double_hazard_mem", 1, FWD ? 32'h10 : 32'hAAAA, FWD ? 32'h10 : 32'hBBBB,
                 FWD ? 32'h10 : 32'hBBBB, 3'b010, 5'd7, 1, 0, 0, 0,
                 FWD ? 2'b10 : 2'b00, FWD ? 2'b10 : 2'b00));

    next();
    stall = 1'b1;
    fw(5'd5, 0, 32'h10, 5'd5, 1, 32'h20);
    tick_push(mk("double_hazard_wb", 1, FWD ? 32'h20 : 32'hAAAA, FWD ? 32'h20 : 32'hBBBB,
                 FWD ? 32'h20 : 32'hBBBB, 3'b010, 5'd7, 1, 0, 0, 0,
                 FWD ? 2'b01 : 2'b00, FWD ? 2'b01 : 2'b00));

    next();
    stall = 1'b0;
    drive(1, 32'h1234, 32'h5, 32'h0, 5'd0, 5'd2, 5'd8, 3'b001, 0, 1, 0, 0, 0);
    fw(5'd0, 1, 32'hFFFF, 5'd0, 0, 32'h0);
    tick_push(mk("reg_zero", 1, 32'h1234, 32'h5, 32'h5, 3'b001, 5'd8, 1, 0, 0, 0, 2'b00, 2'b00));

    next();
    drive(1, 32'h33, 32'h44, 32'h0, 5'd3, 5'd4, 5'd9, 3'b110, 0, 1, 0, 0, 0);
    fw(5'd4, 1, 32'h99, 5'd3, 1, 32'h77);
    tick_push(mk("split_fwd", 1, FWD ? 32'h77 : 32'h33, FWD ? 32'h99 : 32'h44,
                 FWD ? 32'h99 : 32'h44, 3'b110, 5'd9, 1, 0, 0, 0,
                 FWD ? 2'b01 : 2'b00, FWD ? 2'b10 : 2'b00));

    next();
    drive(1, 32'h100, 32'h66, 32'hFFFF_FFFC, 5'd1, 5'd6, 5'd6, 3'b010, 1, 0, 0, 1, 0);
    fw(5'd0, 0, 32'h0, 5'd6, 1, 32'h55);
    imm_exp = mk("imm_store", 1, 32'h100, 32'hFFFF_FFFC, FWD ? 32'h55 : 32'h66, 3'b010,
                 5'd6, 0, 0, 1, 0, 2'b00, FWD ? 2'b01 : 2'b00);
    tick_push(imm_exp);

    next();
    stall = 1'b1;
    drive(1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1, 5'd7, 5'd8, 5'd9, 3'b111, 0, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      imm_exp.name = $sformatf("stall_hold_%0d", i);
      tick_push(imm_exp);
      next();
    end

    flush = 1'b1;
    tick_push(bubble("stall_flush"));

    next();
    stall = 1'b0; flush = 1'b0;
    drive(1, 32'h9, 32'hA, 32'h1, 5'd9, 5'd10, 5'd11, 3'b111, 0, 1, 1, 0, 1);
    fw(0, 0, 0, 0, 0, 0);
    tick_push(mk("slt_load", 1, 32'h9, 32'hA, 32'hA, 3'b111, 5'd11, 1, 1, 0, 1, 2'b00, 2'b00));

    next();
    drive(0, 32'h9, 32'hA, 32'h1, 5'd9, 5'd10, 5'd11, 3'b111, 0, 1, 1, 0, 1);
    tick_push(bubble("id_invalid"));

    next();
    drive(1, 32'hC, 32'hD, 32'h0, 5'd12, 5'd13, 5'd14, 3'b110, 0, 1, 0, 0, 0);
    tick_push(mk("sub_load", 1, 32'hC, 32'hD, 32'hD, 3'b110, 5'd14, 1, 0, 0, 0, 2'b00, 2'b00));

    next();
    flush = 1'b1;
    tick_push(bubble("flush_only"));

    next();
    flush = 1'b0;
    drive(1, 32'h7, 32'h8, 32'h0, 5'd1, 5'd2, 5'd5, 3'b000, 0, 1, 0, 0, 0);
    tick_push(mk("and_load", 1, 32'h7, 32'h8, 32'h8, 3'b000, 5'd5, 1, 0, 0, 0, 2'b00, 2'b00));

    next();
    rst_n = 1'b0;
    #1 q.push_back(bubble("reset_midrun"));

    next();
    rst_n = 1'b1;
    drive(1, 32'h21, 32'h31, 32'h0, 5'd2, 5'd3, 5'd4, 3'b001, 0, 1, 0, 0, 0);
    tick_push(mk("post_reset_load", 1, 32'h21, 32'h31, 32'h31, 3'b001, 5'd4, 1, 0, 0, 0, 2'b00, 2'b00));

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      $display("FAIL drain: pending=%0d required=0", q.size());
      n_total += q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
